rd_mutex_scoreboard: RTL and testbench
======================================

// Module: rd_mutex_scoreboard
// PURPOSE
// - Tracks resource ownership for instructions that have left the read stage but not yet retired in write.
// - Keeps an in-order FIFO of per-instruction mutex vectors, pushed on rd issue and popped on write retire.
// - Drives the rd_mutex_busy_* bits consumed by read_commands.
// - Produces the combined read-stage stall from the rd_req_* bits.
// PARAMETERS
// - DEPTH  4   in-flight entries; power of two, 2..8
// - MW     11  mutex vector width; bit map is fixed, see BEHAVIOUR
// PORTS
// - clk               in   1       clock
// - rst_n             in   1       asynchronous active-low reset
// - rd_issue          in   1       rd stage hands an instruction to execute this cycle
// - rd_issue_mutex    in   MW      resources written by the issuing instruction
// - wr_retire         in   1       oldest in-flight instruction completes write stage
// - wr_flush          in   1       exception/branch flush; discards all entries
// - rd_req            in   MW      resources the rd-stage instruction needs to read (rd_req_* packed)
// - rd_issue_accept   out  1       issue accepted this cycle
// - rd_mutex_busy     out  MW      OR of mutex vectors of all valid entries
// - rd_mutex_stall    out  1       |(rd_mutex_busy & rd_req), or rd_issue while full
// - sb_count          out  4       number of valid entries, 0..DEPTH
// - sb_full           out  1       sb_count == DEPTH
// - sb_empty          out  1       sb_count == 0
// BEHAVIOUR
// - Bit map: [10]active [9]memory [8]eflags [7]ebp [6]esp [5]edx [4]ecx [3]eax [2]modregrm_reg [1]modregrm_rm [0]implicit_reg.
// - Reset (async, rst_n=0):
//   - all entries invalid; rd/wr pointers 0; sb_count=0.
//   - rd_mutex_busy=0, sb_empty=1, sb_full=0, rd_issue_accept=0, rd_mutex_stall=0.
// - Storage: DEPTH x MW registers plus a valid bit each. Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
// - rd_issue_accept = rd_issue & (!sb_full | wr_retire) & !wr_flush. Combinational, same cycle.
// - Push: on posedge with accept, write rd_issue_mutex | (1<<10) at wr_ptr; wr_ptr+1; valid set.
//   - The active bit is always set on a stored entry.
// - Pop: on posedge with wr_retire & !sb_empty, clear valid at rd_ptr; rd_ptr+1.
//   - wr_retire while empty is ignored: no pointer move, no error.
// - Simultaneous push and pop: sb_count unchanged.
//   - When full, the pop frees the slot the push uses in the same edge.
// - wr_flush has priority over push and pop. Next edge: all valid cleared, pointers 0, count 0.
// - rd_mutex_busy is combinational from registered state: OR over valid entries. Zero latency after the edge.
// - rd_mutex_stall = |(rd_mutex_busy & rd_req) | (rd_issue & !rd_issue_accept).
// - sb_count: registered, saturating in [0, DEPTH]. Never exceeds DEPTH; never underflows.
// - A flush asserted mid-reset has no effect; reset dominates.
// CONFIGURATION
// - RD_MUTEX_RETIRE_BYPASS_EN defined:
//   - Entry at rd_ptr is excluded from rd_mutex_busy when wr_retire & !sb_empty in that cycle.
//   - With wr_flush=1, rd_mutex_busy=0 in that cycle.
//   - rd_mutex_stall uses this bypassed busy. Removes one stall cycle on back-to-back dependencies.
// - Not defined: rd_mutex_busy reflects registered valid entries only. Retire/flush take effect after the edge.
// TESTING
// - Reset then idle -> busy=0, count=0, empty=1, stall=0 for 10 cycles.
// - Issue mutex 11'h008 (eax), rd_req=11'h008 next cycle -> busy=11'h408, stall=1.
//   - Retire -> busy=0 after the edge. With the bypass macro, stall=0 in the retire cycle.
// - Issue 4 distinct vectors (8'h01,02,04,08 low bits) -> full=1, count=4.
//   - 5th issue without retire -> accept=0, stall=1.
//   - 5th issue with retire -> accept=1, count stays 4, pointer wraps to 0.
// - Fill 3 entries, assert wr_flush with rd_issue=1 -> accept=0; next cycle count=0, busy=0, empty=1.
// - wr_retire on empty for 3 cycles -> count=0, pointers unchanged.
//   - Subsequent issue/retire round-trip returns the same vector order.
// - Assert rst_n=0 asynchronously mid-stream with count=2 -> outputs reach reset values before the next clk edge.

Source files
------------

// File: rtl/rd_mutex_scoreboard.sv
// In-order scoreboard of write-resource mutex vectors held between rd issue and wr retire; drives busy bits and rd stall.
// Optional macro RD_MUTEX_RETIRE_BYPASS_EN: a retiring or flushed entry stops contributing to busy in its own cycle.
module rd_mutex_scoreboard #(
  parameter int DEPTH = 4,
  parameter int MW    = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_rd_issue,
  input  logic [MW-1:0] i_rd_issue_mutex,
  input  logic          i_wr_retire,
  input  logic          i_wr_flush,
  input  logic [MW-1:0] i_rd_req,
  output logic          o_rd_issue_accept,
  output logic [MW-1:0] o_rd_mutex_busy,
  output logic          o_rd_mutex_stall,
  output logic [3:0]    o_sb_count,
  output logic          o_sb_full,
  output logic          o_sb_empty
);

  localparam int            PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]    CNT_MAX    = 4'(DEPTH);
  localparam logic [MW-1:0] ACTIVE_BIT = {1'b1, {(MW-1){1'b0}}};

  logic [MW-1:0] r_mutex [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [3:0]       r_count;

  logic          w_push;
  logic          w_pop;
  logic          w_drop_head;
  logic [MW-1:0] w_busy;

  assign o_sb_count = r_count;
  assign o_sb_full  = (r_count == CNT_MAX);
  assign o_sb_empty = (r_count == 4'd0);

  // rst_n gates the combinational outputs so nothing leaks out while reset is held.
  assign o_rd_issue_accept = rst_n & i_rd_issue & (~o_sb_full | i_wr_retire) & ~i_wr_flush;
  assign w_push = o_rd_issue_accept;
  assign w_pop  = i_wr_retire & ~o_sb_empty & ~i_wr_flush;

`ifdef RD_MUTEX_RETIRE_BYPASS_EN
  assign w_drop_head     = i_wr_retire & ~o_sb_empty;
  assign o_rd_mutex_busy = i_wr_flush ? '0 : w_busy;
`else
  assign w_drop_head     = 1'b0;
  assign o_rd_mutex_busy = w_busy;
`endif

  always_comb begin
    w_busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && !(w_drop_head && (PW'(i) == r_rd_ptr))) begin
        w_busy = w_busy | r_mutex[i];
      end
    end
  end

  assign o_rd_mutex_stall = rst_n & ((|(o_rd_mutex_busy & i_rd_req)) | (i_rd_issue & ~o_rd_issue_accept));

  // Pop is applied before push so a full-queue push reuses the slot freed on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mutex[i] <= '0;
      r_valid  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_wr_flush) begin
      r_valid  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_pop) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr          <= r_rd_ptr + PW'(1);
      end
      if (w_push) begin
        r_mutex[r_wr_ptr] <= i_rd_issue_mutex | ACTIVE_BIT;
        r_valid[r_wr_ptr] <= 1'b1;
        r_wr_ptr          <= r_wr_ptr + PW'(1);
      end
      if (w_push && !w_pop && (r_count != CNT_MAX)) begin
        r_count <= r_count + 4'd1;
      end else if (w_pop && !w_push && (r_count != 4'd0)) begin
        r_count <= r_count - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_rd_mutex_scoreboard.sv
// Directed bench for rd_mutex_scoreboard: reset, dependency stall, full/wrap, flush, empty retire, async reset.
module tb_rd_mutex_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        rd_issue;
  logic [10:0] rd_issue_mutex;
  logic        wr_retire;
  logic        wr_flush;
  logic [10:0] rd_req;
  logic        accept;
  logic [10:0] busy;
  logic        stall;
  logic [3:0]  count;
  logic        full;
  logic        empty;

  int n_total;
  int n_pass;

`ifdef RD_MUTEX_RETIRE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  rd_mutex_scoreboard #(.DEPTH(4), .MW(11)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_rd_issue        (rd_issue),
    .i_rd_issue_mutex  (rd_issue_mutex),
    .i_wr_retire       (wr_retire),
    .i_wr_flush        (wr_flush),
    .i_rd_req          (rd_req),
    .o_rd_issue_accept (accept),
    .o_rd_mutex_busy   (busy),
    .o_rd_mutex_stall  (stall),
    .o_sb_count        (count),
    .o_sb_full         (full),
    .o_sb_empty        (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst_n = 1'b0; rd_issue = 1'b0; rd_issue_mutex = '0;
    wr_retire = 1'b0; wr_flush = 1'b1; rd_req = '0;
    #2;
    check("rst_accept", accept, 0);
    check("rst_stall", stall, 0);
    repeat (2) tick();
    wr_flush = 1'b0;
    rst_n = 1'b1;
    settle();
    check("rst_full", full, 0);
    check("rst_accept_after", accept, 0);
    for (int c = 0; c < 10; c++) begin
      tick();
      check("idle_busy", busy, 0);
      check("idle_count", count, 0);
      check("idle_empty", empty, 1);
      check("idle_stall", stall, 0);
    end

    // Single eax dependency
    rd_issue = 1'b1; rd_issue_mutex = 11'h008;
    settle();
    check("dep_accept", accept, 1);
    tick();
    rd_issue = 1'b0; rd_issue_mutex = '0; rd_req = 11'h008;
    settle();
    check("dep_busy", busy, 11'h408);
    check("dep_stall", stall, 1);
    check("dep_count", count, 1);
    wr_retire = 1'b1;
    settle();
    check("dep_retire_stall", stall, BYP ? 0 : 1);
    check("dep_retire_busy", busy, BYP ? 11'h000 : 11'h408);
    tick();
    wr_retire = 1'b0;
    settle();
    check("dep_after_busy", busy, 0);
    check("dep_after_stall", stall, 0);
    check("dep_after_empty", empty, 1);
    rd_req = '0;

    // Fill to DEPTH, then overflow attempts
    for (int k = 0; k < 4; k++) begin
      rd_issue = 1'b1; rd_issue_mutex = 11'(1 << k);
      tick();
    end
    rd_issue = 1'b0;
    settle();
    check("fill_full", full, 1);
    check("fill_count", count, 4);
    check("fill_busy", busy, 11'h40F);
    rd_issue = 1'b1; rd_issue_mutex = 11'h010;
    settle();
    check("ovf_accept", accept, 0);
    check("ovf_stall", stall, 1);
    tick();
    check("ovf_count", count, 4);
    check("ovf_busy", busy, 11'h40F);
    wr_retire = 1'b1;
    settle();
    check("wrap_accept", accept, 1);
    check("wrap_stall", stall, 0);
    tick();
    rd_issue = 1'b0; wr_retire = 1'b0;
    settle();
    check("wrap_count", count, 4);
    check("wrap_busy", busy, 11'h41E);
    begin
      logic [10:0] drain_exp [4];
      drain_exp[0] = 11'h41C; drain_exp[1] = 11'h418;
      drain_exp[2] = 11'h410; drain_exp[3] = 11'h000;
      for (int k = 0; k < 4; k++) begin
        wr_retire = 1'b1;
        tick();
        wr_retire = 1'b0;
        settle();
        check("drain_busy", busy, drain_exp[k]);
        check("drain_count", count, 3 - k);
      end
    end

    // Flush with a concurrent issue
    for (int k = 0; k < 3; k++) begin
      rd_issue = 1'b1; rd_issue_mutex = 11'(1 << k);
      tick();
    end
    rd_issue_mutex = 11'h020; wr_flush = 1'b1;
    settle();
    check("flush_count_pre", count, 3);
    check("flush_accept", accept, 0);
    check("flush_stall", stall, 1);
    check("flush_busy_same", busy, BYP ? 11'h000 : 11'h407);
    tick();
    rd_issue = 1'b0; wr_flush = 1'b0;
    settle();
    check("flush_count", count, 0);
    check("flush_busy", busy, 0);
    check("flush_empty", empty, 1);

    // Retire while empty must not move pointers
    wr_retire = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("empty_retire_count", count, 0);
    end
    wr_retire = 1'b0;
    rd_issue = 1'b1; rd_issue_mutex = 11'h040;
    tick();
    rd_issue_mutex = 11'h080;
    tick();
    rd_issue = 1'b0;
    settle();
    check("rt_busy2", busy, 11'h4C0);
    wr_retire = 1'b1;
    tick();
    wr_retire = 1'b0;
    settle();
    check("rt_order1", busy, 11'h480);
    wr_retire = 1'b1;
    tick();
    wr_retire = 1'b0;
    settle();
    check("rt_order2", busy, 11'h000);
    check("rt_empty", empty, 1);

    // Asynchronous reset mid-stream
    rd_issue = 1'b1; rd_issue_mutex = 11'h001;
    tick();
    rd_issue_mutex = 11'h002;
    tick();
    rd_issue_mutex = 11'h004; rd_req = 11'h003;
    settle();
    check("arst_pre_count", count, 2);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_count", count, 0);
    check("arst_busy", busy, 0);
    check("arst_empty", empty, 1);
    check("arst_accept", accept, 0);
    check("arst_stall", stall, 0);
    rd_issue = 1'b0; rd_req = '0;
    tick();
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
